// File: rtl/dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bus_ctrl
// Description : Data-memory bus controller for the MEM stage. Accepts
//               load/store requests (word or byte) and executes them as
//               little-endian byte beats on an 8-bit SRAM-style bus with
//               wait states and a per-beat timeout. Stalls the pipeline
//               while an access is in flight and returns load data.
// Ports       : clk, rst_n                 clock, async active-low reset
//               req_en/rw/byte/addr/wdata  request from the MEM stage
//               stall                      hold MEM and earlier stages
//               done, rd_valid, err        one-cycle completion pulses
//               rd_data                    load result (held until next load)
//               mem_addr/re/we/wdata       external byte bus, outputs
//               mem_rdata, mem_ready       external byte bus, inputs
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bus_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_en,
  input  logic              req_rw,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              done,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  localparam int                BEATS     = DATA_W / 8;
  localparam int                BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  // The abort fires on the cycle the wait counter would reach TIMEOUT.
  localparam logic [7:0]        WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic              rw;
  logic              is_byte;
  logic              err_flag;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdbuf;
  logic [DATA_W-1:0] rdbuf_next;
  logic [BEAT_W-1:0] beat;
  logic [7:0]        wait_cnt;
  logic [7:0]        wr_lane;
  logic              misaligned;
  logic              last_beat;

  assign misaligned = ~req_byte & (req_addr[1:0] != 2'b00);
  assign last_beat  = is_byte | (beat == LAST_BEAT);

  // Byte-lane steering: merge the incoming read byte into lane [beat] and
  // pick the outgoing write byte from lane [beat].
  always_comb begin
    rdbuf_next = rdbuf;
    wr_lane    = 8'h00;
    for (int i = 0; i < BEATS; i++) begin
      if (beat == i[BEAT_W-1:0]) begin
        rdbuf_next[8*i +: 8] = mem_rdata;
        wr_lane              = wdata[8*i +: 8];
      end
    end
  end

  // Outputs decode from registered state only, except the request-cycle
  // stall, which must react in the same cycle the request is presented.
  // That term is gated by rst_n so every output is low while in reset.
  always_comb begin
    stall     = 1'b0;
    done      = 1'b0;
    rd_valid  = 1'b0;
    err       = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    case (state)
      IDLE: begin
        stall = rst_n & req_en & ~misaligned;
      end
      ACCESS: begin
        stall     = 1'b1;
        mem_re    = ~rw;
        mem_we    = rw;
        mem_addr  = base + ADDR_W'(beat);
        mem_wdata = rw ? wr_lane : 8'h00;
      end
      DONE: begin
        done     = 1'b1;
        err      = err_flag;
        rd_valid = ~rw & ~err_flag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base     <= '0;
      rw       <= 1'b0;
      is_byte  <= 1'b0;
      err_flag <= 1'b0;
      wdata    <= '0;
      rdbuf    <= '0;
      rd_data  <= '0;
      beat     <= '0;
      wait_cnt <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (req_en) begin
            rw <= req_rw;
            if (misaligned) begin
              // Rejected without touching the bus; report in the next cycle.
              err_flag <= 1'b1;
              state    <= DONE;
            end else begin
              base     <= req_addr;
              is_byte  <= req_byte;
              wdata    <= req_wdata;
              beat     <= '0;
              wait_cnt <= 8'h00;
              rdbuf    <= '0;      // upper lanes stay zero for byte loads
              err_flag <= 1'b0;
              state    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            wait_cnt <= 8'h00;
            if (!rw) begin
              rdbuf <= rdbuf_next;
            end
            if (last_beat) begin
              if (!rw) begin
                rd_data <= rdbuf_next;
              end
              state <= DONE;
            end else begin
              beat <= beat + 1'b1;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            err_flag <= 1'b1;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          err_flag <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_bus_ctrl
// Description : Self-checking bench for dmem_bus_ctrl. A transaction-level
//               model expands each request into the expected per-cycle bus
//               activity; a compare process checks every cycle. A simple
//               SRAM model with scripted wait states answers the bus.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_bus_ctrl;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_en = 1'b0;
  logic              req_rw = 1'b0;
  logic              req_byte = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              stall;
  logic              done;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ready = 1'b0;

  dmem_bus_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_en(req_en), .req_rw(req_rw), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .rd_valid(rd_valid), .rd_data(rd_data),
    .err(err), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  logic [7:0] sram    [0:65535];
  logic [7:0] exp_mem [0:65535];
  logic       sram_loaded = 1'b0;

  function automatic logic [7:0] pat(input int a);
    case (a)
      'h05:    return 8'h9C;
      'h10:    return 8'h11;
      'h11:    return 8'h22;
      'h12:    return 8'h33;
      'h13:    return 8'h44;
      default: return 8'(a) ^ 8'hA5;
    endcase
  endfunction

  assign mem_rdata = mem_re ? sram[mem_addr] : 8'h00;

  always @(posedge clk) begin
    if (!sram_loaded) begin
      for (int a = 0; a < 65536; a++) sram[a] <= pat(a);
      sram_loaded <= 1'b1;
    end else if (rst_n && mem_we && mem_ready) begin
      sram[mem_addr] <= mem_wdata;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int passed = 0;
  logic [DATA_W-1:0] exp_rd = '0;

  typedef struct {
    logic        stall, done, rd_valid, err, re, we;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];
  bit   rdy_sched[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  always @(negedge clk) begin : cmp
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall",     32'(stall),     32'(e.stall));
      chk("done",      32'(done),      32'(e.done));
      chk("rd_valid",  32'(rd_valid),  32'(e.rd_valid));
      chk("err",       32'(err),       32'(e.err));
      chk("mem_re",    32'(mem_re),    32'(e.re));
      chk("mem_we",    32'(mem_we),    32'(e.we));
      chk("mem_addr",  32'(mem_addr),  32'(e.addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e.wd));
      chk("rd_data",   rd_data,        e.rd);
    end
  end

  // ---------------- transaction-level model ----------------
  function automatic exp_t blank();
    exp_t e;
    e.stall = 1'b0; e.done = 1'b0; e.rd_valid = 1'b0; e.err = 1'b0;
    e.re = 1'b0; e.we = 1'b0; e.addr = '0; e.wd = '0; e.rd = exp_rd;
    return e;
  endfunction

  function automatic exp_t acc_rec(input logic rw, input logic [15:0] addr,
                                   input int b, input logic [31:0] wd);
    exp_t e;
    e = blank();
    e.stall = 1'b1;
    e.re    = ~rw;
    e.we    = rw;
    e.addr  = 16'(addr + 16'(b));
    e.wd    = rw ? wd[8*b +: 8] : 8'h00;
    return e;
  endfunction

  // Builds the expected cycle sequence for one request, then drives it.
  // waits = not-ready cycles before each beat; >= TIMEOUT means stuck bus.
  task automatic do_req(input logic rw, input logic byt, input logic [15:0] addr,
                        input logic [31:0] wd, input int waits, output int ncyc);
    exp_t        e;
    logic        mis, to;
    int          nb, nw;
    logic [31:0] rdv;
    mis  = !byt && (addr[1:0] != 2'b00);
    to   = !mis && (waits >= TIMEOUT);
    nb   = byt ? 1 : 4;
    rdv  = '0;
    ncyc = 0;
    e = blank();
    e.stall = !mis;
    exp_q.push_back(e); rdy_sched.push_back(1'b0); ncyc++;
    if (!mis) begin
      for (int b = 0; b < (to ? 1 : nb); b++) begin
        nw = to ? TIMEOUT : waits;
        for (int w = 0; w < nw; w++) begin
          exp_q.push_back(acc_rec(rw, addr, b, wd)); rdy_sched.push_back(1'b0); ncyc++;
        end
        if (!to) begin
          exp_q.push_back(acc_rec(rw, addr, b, wd)); rdy_sched.push_back(1'b1); ncyc++;
          if (rw) exp_mem[16'(addr + 16'(b))] = wd[8*b +: 8];
          else    rdv[8*b +: 8] = exp_mem[16'(addr + 16'(b))];
        end
      end
    end
    if (!rw && !mis && !to) exp_rd = rdv;
    e = blank();
    e.done     = 1'b1;
    e.err      = mis | to;
    e.rd_valid = !rw && !mis && !to;
    exp_q.push_back(e); rdy_sched.push_back(1'b0); ncyc++;
    for (int i = 0; i < ncyc; i++) begin
      req_en = 1'b1;
      if (i == 0) begin
        req_rw = rw; req_byte = byt; req_addr = addr; req_wdata = wd;
      end else begin
        // Garbage on the request port while busy must be ignored.
        req_rw = ~rw; req_byte = ~byt; req_addr = ~addr; req_wdata = ~wd;
      end
      mem_ready = rdy_sched.pop_front();
      @(posedge clk); #1;
    end
    req_en = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(blank());
      req_en = 1'b0;
      mem_ready = i[0];   // stray ready while idle must do nothing
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    for (int a = 0; a < 65536; a++) exp_mem[a] = pat(a);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst stall",     32'(stall),     32'h0);
    chk("rst done",      32'(done),      32'h0);
    chk("rst err",       32'(err),       32'h0);
    chk("rst mem_re",    32'(mem_re),    32'h0);
    chk("rst mem_we",    32'(mem_we),    32'h0);
    chk("rst mem_addr",  32'(mem_addr),  32'h0);
    chk("rst mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst rd_data",   rd_data,        32'h0);
    rst_n = 1'b1;
    idle(2);

    // LDW 0x0010, no waits
    do_req(1'b0, 1'b0, 16'h0010, 32'h0, 0, n);
    chk("ldw cycles", 32'(n), 32'd6);
    chk("ldw data",   rd_data, 32'h44332211);

    // STB 0x0007
    do_req(1'b1, 1'b1, 16'h0007, 32'hDEADBEEF, 0, n);
    chk("stb cycles",  32'(n), 32'd3);
    chk("stb byte",    32'(sram[7]), 32'h0000_00EF);
    chk("stb below",   32'(sram[6]), 32'h0000_00A3);
    chk("stb above",   32'(sram[8]), 32'h0000_00AD);
    chk("stb rd hold", rd_data, 32'h44332211);

    // LDB 0x0005 with 3 wait states
    do_req(1'b0, 1'b1, 16'h0005, 32'h0, 3, n);
    chk("ldb cycles", 32'(n), 32'd6);
    chk("ldb data",   rd_data, 32'h0000009C);

    // LDW 0x0002 misaligned
    do_req(1'b0, 1'b0, 16'h0002, 32'h0, 0, n);
    chk("mis cycles",  32'(n), 32'd2);
    chk("mis rd hold", rd_data, 32'h0000009C);
    idle(1);

    // STW with one wait per beat, then read back
    do_req(1'b1, 1'b0, 16'h0040, 32'hCAFEF00D, 1, n);
    chk("stw cycles", 32'(n), 32'd10);
    do_req(1'b0, 1'b0, 16'h0040, 32'h0, 0, n);
    chk("stw readback", rd_data, 32'hCAFEF00D);

    // STW with bus stuck -> timeout on beat 0
    do_req(1'b1, 1'b0, 16'h0050, 32'h01020304, 99, n);
    chk("to cycles",   32'(n), 32'd6);
    chk("to untouched", 32'(sram[16'h50]), 32'h0000_00F5);
    do_req(1'b0, 1'b0, 16'h0050, 32'h0, 2, n);
    chk("to readback", rd_data, 32'hF6F7F4F5);

    // LDB at top of address space
    do_req(1'b0, 1'b1, 16'hFFFF, 32'h0, 0, n);
    chk("ldb top", rd_data, 32'h0000005A);
    idle(1);

    // Async reset during beat 2 of a STW
    exp_q.push_back(blank());
    exp_q[$].stall = 1'b1;
    exp_q.push_back(acc_rec(1'b1, 16'h0060, 0, 32'h12345678));
    exp_q.push_back(acc_rec(1'b1, 16'h0060, 1, 32'h12345678));
    for (int i = 0; i < 3; i++) begin
      req_en = (i == 0); req_rw = 1'b1; req_byte = 1'b0;
      req_addr = 16'h0060; req_wdata = 32'h12345678;
      mem_ready = (i != 0);
      @(posedge clk); #1;
    end
    exp_mem[16'h60] = 8'h78;
    exp_mem[16'h61] = 8'h56;
    mem_ready = 1'b1;
    chk("pre-rst we",    32'(mem_we),    32'h1);
    chk("pre-rst addr",  32'(mem_addr),  32'h0062);
    chk("pre-rst wdata", 32'(mem_wdata), 32'h34);
    #2 rst_n = 1'b0;
    #1;
    chk("arst stall",   32'(stall),    32'h0);
    chk("arst mem_we",  32'(mem_we),   32'h0);
    chk("arst mem_re",  32'(mem_re),   32'h0);
    chk("arst addr",    32'(mem_addr), 32'h0);
    chk("arst wdata",   32'(mem_wdata),32'h0);
    chk("arst rd_data", rd_data,       32'h0);
    exp_rd = '0;
    req_en = 1'b1; req_byte = 1'b1; req_rw = 1'b0;
    @(posedge clk); #1;
    chk("arst stall req", 32'(stall), 32'h0);
    req_en = 1'b0; mem_ready = 1'b0;
    rst_n = 1'b1;
    idle(2);
    chk("arst byte1", 32'(sram[16'h61]), 32'h56);
    chk("arst byte2", 32'(sram[16'h62]), 32'hC7);
    do_req(1'b0, 1'b1, 16'h0061, 32'h0, 0, n);
    chk("post-rst ldb", rd_data, 32'h00000056);
    do_req(1'b0, 1'b0, 16'h0060, 32'h0, 0, n);
    chk("post-rst ldw", rd_data, 32'hC6C75678);
    idle(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
